// File: rtl/nbody_pkg.sv
// nbody_pkg: shared widths, body record type and scheduler state encoding.
package nbody_pkg;
    localparam int ADDR_W         = 15;
    localparam int BODY_W         = 80;
    localparam int BODY_BASE_DEF  = 0;
    localparam int FORCE_BASE_DEF = 400;

    typedef logic [BODY_W-1:0] body_t;

    typedef enum logic [2:0] {IDLE, FETCH_I, FETCH_J, ISSUE, ROW_END, DONE} sched_state_t;
endpackage

// File: rtl/nbody_ram_fetch.sv
// nbody_ram_fetch: counts RD_LAT cycles for a held read address and pulses rvalid with the data.
module nbody_ram_fetch
    import nbody_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  en_i,
    input  body_t rdata_i,
    output logic  rvalid_o,
    output body_t data_o
);
    localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign rvalid_o = en_i && (cnt_q == CW'(RD_LAT));
    assign data_o   = rdata_i;

    // restarting on rvalid lets back-to-back fetches share the counter
    always_comb cnt_d = (!en_i || rvalid_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/nbody_pair_scheduler.sv
// nbody_pair_scheduler: all-pairs N-body fetch/issue/flush sequencer over the body RAM.
// Define NBODY_SYMMETRIC_EN to issue only j > i pairs (Newton's third law).
module nbody_pair_scheduler
    import nbody_pkg::*;
#(
    parameter int N          = 2,
    parameter int RD_LAT     = 2,
    parameter int BODY_BASE  = BODY_BASE_DEF,
    parameter int FORCE_BASE = FORCE_BASE_DEF,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              done,
    output logic              busy,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  body_t             mem_rdata,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [IDX_W-1:0]  pair_i,
    output logic [IDX_W-1:0]  pair_j,
    output body_t             body_i,
    output body_t             body_j,
    output logic              flush,
    output logic [ADDR_W-1:0] flush_addr,
    output logic [31:0]       pair_count
);
    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
    body_t             bi_q, bi_d, bj_q, bj_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic              rvalid;
    body_t             fdata;
    logic [IDX_W:0]    j_first, j_next;

    // one extra bit so j can step past N-1 without wrapping
`ifdef NBODY_SYMMETRIC_EN
    assign j_first = {1'b0, i_q} + 1'b1;
    assign j_next  = {1'b0, j_q} + 1'b1;
`else
    logic [IDX_W:0] j_inc;
    assign j_inc   = {1'b0, j_q} + 1'b1;
    assign j_first = (i_q == '0) ? (IDX_W+1)'(1) : '0;
    assign j_next  = (j_inc == {1'b0, i_q}) ? j_inc + 1'b1 : j_inc;
`endif

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign pair_valid = (state_q == ISSUE);
    assign flush      = (state_q == ROW_END);
    assign pair_i     = i_q;
    assign pair_j     = j_q;
    assign body_i     = bi_q;
    assign body_j     = bj_q;
    assign flush_addr = fa_q;
    assign pair_count = cnt_q;
    assign mem_addr   = busy ? ADDR_W'(BODY_BASE) + ADDR_W'((state_q == FETCH_J) ? j_q : i_q)
                             : test_addr;

    nbody_ram_fetch #(.RD_LAT(RD_LAT)) u_fetch (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     ((state_q == FETCH_I) || (state_q == FETCH_J)),
        .rdata_i  (mem_rdata),
        .rvalid_o (rvalid),
        .data_o   (fdata)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        bi_d    = bi_q;
        bj_d    = bj_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                i_d     = '0;
                cnt_d   = '0;
                state_d = FETCH_I;
            end
            FETCH_I: if (rvalid) begin
                bi_d    = fdata;
                j_d     = j_first[IDX_W-1:0];
                state_d = (int'(j_first) < N) ? FETCH_J : ROW_END;
            end
            FETCH_J: if (rvalid) begin
                bj_d    = fdata;
                state_d = ISSUE;
            end
            ISSUE: if (pair_ready) begin
                cnt_d   = cnt_q + 32'(cnt_q != '1);
                j_d     = j_next[IDX_W-1:0];
                state_d = (int'(j_next) < N) ? FETCH_J : ROW_END;
            end
            ROW_END: begin
                i_d     = (int'(i_q) == N - 1) ? i_q : i_q + 1'b1;
                state_d = (int'(i_q) == N - 1) ? DONE : FETCH_I;
            end
            default: state_d = IDLE;
        endcase
        fa_d = (state_d == ROW_END) ? ADDR_W'(FORCE_BASE) + ADDR_W'(i_q) : fa_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            bi_q    <= '0;
            bj_q    <= '0;
            cnt_q   <= '0;
            fa_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            bi_q    <= bi_d;
            bj_q    <= bj_d;
            cnt_q   <= cnt_d;
            fa_q    <= fa_d;
        end
endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// tb_nbody_pair_scheduler: runs N=1..4 schedulers against an all-pairs event model.
// Honours NBODY_SYMMETRIC_EN in the model so the same bench covers both builds.
module tb_nbody_pair_scheduler;
    logic        clk = 0, reset_n = 0;
    logic [14:0] test_addr;
    logic        pv[4], fl[4], dn[4], bz[4], st[4], rdy[4];
    logic [7:0]  pi_a[4], pj_a[4];
    logic [79:0] bi_a[4], bj_a[4], rd[4];
    logic [14:0] ma[4], fa[4];
    logic [31:0] pc[4];
    logic [79:0] ram[16];
    bit          held[4];
    logic [175:0] hold_v[4];
    int          n_chk = 0, n_fail = 0;
    logic [191:0] obs[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int NN = g + 1;
        localparam int IW = (NN > 1) ? $clog2(NN) : 1;
        logic [IW-1:0] pi, pj;
        logic [79:0]   d1, d2;
        nbody_pair_scheduler #(.N(NN), .RD_LAT(2), .BODY_BASE(0), .FORCE_BASE(400)) u (
            .clk(clk), .reset_n(reset_n), .start(st[g]), .done(dn[g]), .busy(bz[g]),
            .test_addr(test_addr), .mem_addr(ma[g]), .mem_rdata(rd[g]),
            .pair_valid(pv[g]), .pair_ready(rdy[g]), .pair_i(pi), .pair_j(pj),
            .body_i(bi_a[g]), .body_j(bj_a[g]), .flush(fl[g]), .flush_addr(fa[g]),
            .pair_count(pc[g])
        );
        assign pi_a[g] = 8'(pi);
        assign pj_a[g] = 8'(pj);
        always @(posedge clk) begin
            d1 <= ram[ma[g][3:0]];
            d2 <= d1;
        end
        assign rd[g] = d2;
    end

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        for (int k = 0; k < 4; k++) begin
            if (held[k] && reset_n)
                chk("hold_stable", 192'({pv[k], pi_a[k], pj_a[k], bi_a[k], bj_a[k]}), 192'({1'b1, hold_v[k]}));
            if (pv[k] && rdy[k]) obs.push_back({8'd0, 16'(pi_a[k]), pj_a[k], bi_a[k], bj_a[k]});
            if (fl[k]) begin
                chk("flush_excl", 192'(pv[k]), 192'(0));
                obs.push_back({8'd1, 16'(fa[k]), 8'd0, 160'd0});
            end
            held[k]   <= pv[k] && !rdy[k];
            hold_v[k] <= {pi_a[k], pj_a[k], bi_a[k], bj_a[k]};
        end

    task automatic rst_chk(input int g);
        chk("rst_ctl", 192'({pv[g], bz[g], dn[g], fl[g]}), 192'(0));
        chk("rst_cnt", 192'(pc[g]), 192'(0));
        chk("rst_idx", 192'({pi_a[g], pj_a[g], fa[g]}), 192'(0));
        chk("rst_body", 192'({bi_a[g], bj_a[g]}), 192'(0));
    endtask

    // mode 0: ready tied high; 1: random ready and stray starts; 2: ready low 5 cycles per pair
    task automatic run_pass(input int g, input int mode);
        int nn = g + 1, np = 0, w = 0;
        bit ok;
        logic [191:0] exp_q[$];
        for (int a = 0; a < 16; a++) ram[a] = {16'($urandom), $urandom, $urandom};
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < nn; j++) begin
`ifdef NBODY_SYMMETRIC_EN
                ok = j > i;
`else
                ok = j != i;
`endif
                if (ok) begin
                    exp_q.push_back({8'd0, 16'(i), 8'(j), ram[i], ram[j]});
                    np++;
                end
            end
            exp_q.push_back({8'd1, 16'(400 + i), 8'd0, 160'd0});
        end
        obs.delete();
        test_addr = 15'd401;
        @(posedge clk); #1 st[g] = 1;
        @(posedge clk); #1 st[g] = 0;
        chk("start_addr", 192'(ma[g]), 192'(0));
        chk("start_busy", 192'({bz[g], dn[g]}), 192'(2'b10));
        for (int c = 0; c < 3000; c++) begin
            if (dn[g]) break;
            w = pv[g] ? w + 1 : 0;
            rdy[g] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (w > 5);
            if (mode == 1) st[g] = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        st[g] = 0;
        chk("done_timeout", 192'(dn[g]), 192'(1));
        chk("n_events", 192'(obs.size()), 192'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk("event", (k < obs.size()) ? obs[k] : 192'(0), exp_q[k]);
        chk("pair_count", 192'(pc[g]), 192'(np));
        chk("busy_after", 192'(bz[g]), 192'(0));
        test_addr = 15'($urandom);
        #1 chk("fwd_done", 192'(ma[g]), 192'(test_addr));
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin st[k] = 0; rdy[k] = 1; end
        test_addr = 15'd401;
        repeat (3) @(posedge clk);
        #1 rst_chk(1);
        reset_n = 1;
        @(posedge clk); #1 chk("fwd_idle", 192'(ma[1]), 192'(401));
        run_pass(1, 0);
        run_pass(2, 2);
        run_pass(0, 0);
        run_pass(3, 1);
        run_pass(2, 1);
        run_pass(1, 1);
        obs.delete();
        rdy[2] = 0;
        @(posedge clk); #1 st[2] = 1;
        @(posedge clk); #1 st[2] = 0;
        for (int c = 0; c < 100 && !pv[2]; c++) begin
            @(posedge clk); #1;
        end
        chk("reached_issue", 192'(pv[2]), 192'(1));
        reset_n = 0;
        #1 rst_chk(2);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (5) @(posedge clk);
        #1 chk("no_flush_after_rst", 192'(obs.size()), 192'(0));
        chk("idle_after_rst", 192'({bz[2], dn[2]}), 192'(0));
        run_pass(2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nbody_pair_scheduler.md
Name: nbody_pair_scheduler

Overview:
- Sequences the naive all-pairs N-body force pass over the shared 80-bit body RAM.
- Fetches body i once per row and each body j != i, then presents (i, j, body_i, body_j) to the force/accumulate datapath over a valid/ready handshake.
- Pulses a per-row flush carrying force address FORCE_BASE+i.
- Owns the RAM read port while busy; otherwise forwards test_addr so debug reads keep working.

Parameters:
N, 2, number of bodies (>=1)
RD_LAT, 2, body RAM read latency in cycles from mem_addr to valid mem_rdata
BODY_BASE, 0, RAM address of body 0
FORCE_BASE, 400, RAM address of force record for body 0

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE or DONE
done  out  1  level high from pass completion until the next accepted start
busy  out  1  high in every state except IDLE and DONE
test_addr  in  15  debug read address, forwarded when not busy
mem_addr  out  15  body RAM read address
mem_rdata  in  80  body RAM read data
pair_valid  out  1  pair presented
pair_ready  in  1  datapath accepts pair
pair_i  out  IDX_W  index of body i; IDX_W = max(1, $clog2(N))
pair_j  out  IDX_W  index of body j
body_i  out  80  registered body i record
body_j  out  80  registered body j record
flush  out  1  one-cycle pulse: row i complete
flush_addr  out  15  FORCE_BASE + i, valid with flush
pair_count  out  32  pairs accepted in current/last pass

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - done, busy, pair_valid and flush = 0.
  - pair_count, pair_i, pair_j, body_i, body_j and flush_addr = 0.
  - Reset mid-pass abandons the pass; no flush is emitted.
- mem_addr:
  - Busy: the scheduler's fetch address, combinational from state and index.
  - Not busy: test_addr.
- FSM states: IDLE, FETCH_I, FETCH_J, ISSUE, ROW_END, DONE.
- IDLE/DONE + start=1:
  - i=0, pair_count=0, done=0, go to FETCH_I.
  - start while busy is ignored.
- FETCH_I:
  - Drive BODY_BASE+i and wait RD_LAT cycles (wait counter); capture mem_rdata into body_i.
  - Set j to the first valid j (0, or 1 if i==0).
  - If no valid j exists, go to ROW_END; else go to FETCH_J.
- FETCH_J:
  - Drive BODY_BASE+j and wait RD_LAT cycles; capture into body_j.
  - Go to ISSUE with pair_valid=1.
- ISSUE:
  - pair_valid stays high, and pair_i/pair_j/body_i/body_j stay stable, until pair_valid&&pair_ready.
  - On the handshake cycle: pair_count++, advance j to the next j != i.
  - If j wraps past N-1, go to ROW_END; else go to FETCH_J.
  - pair_valid drops the cycle after acceptance.
- ROW_END:
  - flush=1 for exactly one cycle with flush_addr=FORCE_BASE+i.
  - If i==N-1, go to DONE (done=1 next cycle); else i++ and go to FETCH_I.
- Ordering: flush follows the last accepted pair of its row by at least one cycle. Rows with zero pairs still flush.
- Latency: N=2, RD_LAT=2, pair_ready tied high gives exactly 2 pairs and 2 flushes.
- pair_count saturates at 2^32-1.
- Index counters are IDX_W wide. Comparisons against N-1 use full width; no modular wrap.

Optional Feature:
NBODY_SYMMETRIC_EN:
- Defined: j iterates only i+1..N-1 (Newton's third law); downstream applies the negated force to j.
  - Total pairs = N(N-1)/2.
  - Row N-1 has zero pairs but still flushes.
- Undefined: full N(N-1) ordered pairs as above.

Decomposition:
- Package nbody_pkg:
  - body_t (80-bit record), ADDR_W=15, BODY_W=80.
  - FSM state enum sched_state_t.
  - Default BODY_BASE/FORCE_BASE constants.
- Sub-module nbody_ram_fetch:
  - Issues one address, counts RD_LAT cycles and returns a one-cycle rvalid with captured data.
  - Instantiated once and shared by FETCH_I/FETCH_J.

Test Plan:
- N=2, RAM[0]=A, RAM[1]=B, pair_ready=1, start pulse:
  - pairs (0,1,A,B) then (1,0,B,A).
  - flush_addr 400 then 401.
  - done=1, pair_count=2.
- N=3, pair_ready low for 5 cycles per pair:
  - pair_valid held and data stable throughout.
  - 6 pairs in order (0,1),(0,2),(1,0),(1,2),(2,0),(2,1); pair_count=6.
- Idle forwarding:
  - Idle: test_addr=401 -> mem_addr=401.
  - After start: mem_addr=BODY_BASE, ignoring test_addr.
  - After done: mem_addr tracks test_addr again.
- N=1 -> no pair_valid, one flush with flush_addr=400, then done=1, pair_count=0.
- reset_n low during ISSUE of N=3 pass:
  - Outputs zero immediately, state IDLE, no further flush.
  - A new start runs a full 6-pair pass.
- NBODY_SYMMETRIC_EN, N=4:
  - Pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
  - 4 flushes, addresses 400..403; pair_count=6.
